// File: rtl/fht_but_r2.sv
// fht_but_r2: radix-2 FHT butterfly, rotates (x1,x2) by (cos,sin), adds/subtracts from x0, scales by 1/2.
// Optional FHT_BUT_ROUND_EN selects round-half-up instead of floor on the final shift.
module fht_but_r2 #(
  parameter int D_SIZE  = 17,
  parameter int W_SIZE  = 12,
  parameter int W_SHIFT = 10
) (
  input  logic                     iCLK,
  input  logic                     iRESET,
  input  logic signed [D_SIZE-1:0] iX_0,
  input  logic signed [D_SIZE-1:0] iX_1,
  input  logic signed [D_SIZE-1:0] iX_2,
  input  logic signed [W_SIZE-1:0] iSIN,
  input  logic signed [W_SIZE-1:0] iCOS,
  output logic signed [D_SIZE-1:0] oY_0,
  output logic signed [D_SIZE-1:0] oY_1
);
  localparam int MW = D_SIZE + W_SIZE;
  localparam int PW = MW + 1;
  localparam int SW = PW + 1;
`ifdef FHT_BUT_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(1) << (W_SHIFT + 1);
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif
  logic signed [MW-1:0]     m1, m2;
  logic signed [PW-1:0]     p_d, p_q;
  logic signed [SW-1:0]     a, s0, s1, t0, t1;
  logic signed [D_SIZE-1:0] y0_d, y0_q, y1_d, y1_q;
  always_comb begin
    m1   = MW'(iCOS) * MW'(iX_1);
    m2   = MW'(iSIN) * MW'(iX_2);
    p_d  = PW'(m1) + PW'(m2);
    a    = SW'(iX_0) <<< (W_SHIFT + 1);
    s0   = a + SW'(p_q);
    s1   = a - SW'(p_q);
    t0   = s0 + RND;
    t1   = s1 + RND;
    y0_d = D_SIZE'(t0 >>> (W_SHIFT + 2));
    y1_d = D_SIZE'(t1 >>> (W_SHIFT + 2));
  end
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      p_q  <= '0;
      y0_q <= '0;
      y1_q <= '0;
    end else begin
      p_q  <= p_d;
      y0_q <= y0_d;
      y1_q <= y1_d;
    end
  end
  assign oY_0 = y0_q;
  assign oY_1 = y1_q;
endmodule

// File: tb/tb_fht_but_r2.sv
// tb_fht_but_r2: directed table, angle sweep and random streaming checks for fht_but_r2.
module tb_fht_but_r2;
  logic               clk = 0;
  logic               rst;
  logic signed [16:0] x0, x1, x2, y0, y1;
  logic signed [11:0] sn, cs;
  int n_vec = 0, n_err = 0;

  typedef struct {
    int x0, x1, x2, c, s, e0, e1;
  } vec_t;

  vec_t tbl[$];
  vec_t q[$];

  fht_but_r2 dut (
    .iCLK(clk), .iRESET(rst), .iX_0(x0), .iX_1(x1), .iX_2(x2),
    .iSIN(sn), .iCOS(cs), .oY_0(y0), .oY_1(y1)
  );

  always #5 clk = ~clk;

  function automatic int ref_y(input int a0, a1, a2, c, s, input bit neg);
    longint p, t;
    p = longint'(c) * a1 + longint'(s) * a2;
    t = longint'(a0) * 2048 + (neg ? -p : p);
`ifdef FHT_BUT_ROUND_EN
    t = t + 2048;
`endif
    return int'(t >>> 12);
  endfunction

  function automatic vec_t mk(input int a0, a1, a2, c, s);
    vec_t v;
    v.x0 = a0; v.x1 = a1; v.x2 = a2; v.c = c; v.s = s;
    v.e0 = ref_y(a0, a1, a2, c, s, 0);
    v.e1 = ref_y(a0, a1, a2, c, s, 1);
    return v;
  endfunction

  function automatic vec_t hv(input int a0, a1, a2, c, s, e0, e1);
    vec_t v;
    v.x0 = a0; v.x1 = a1; v.x2 = a2; v.c = c; v.s = s; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int e0, input int e1);
    n_vec++;
    if (int'(y0) !== e0 || int'(y1) !== e1 || y0 === 'x || y1 === 'x) begin
      n_err++;
      $display("FAIL %s: got y0=%0d y1=%0d, want y0=%0d y1=%0d", nm, y0, y1, e0, e1);
    end
  endtask

  task automatic range_check(input string nm);
    n_vec++;
    if (int'(y0) > 32767 || int'(y0) < -32768 || int'(y1) > 32767 || int'(y1) < -32768) begin
      n_err++;
      $display("FAIL %s range: got y0=%0d y1=%0d, want |y|<=32767", nm, y0, y1);
    end
  endtask

  // Streams q back to back: coefs of vector i share a cycle with x0 of vector i-1.
  task automatic run_stream(input string nm, input bit rng);
    for (int i = 0; i <= q.size(); i++) begin
      if (i < q.size()) begin
        x1 = 17'(q[i].x1); x2 = 17'(q[i].x2); cs = 12'(q[i].c); sn = 12'(q[i].s);
      end else begin
        x1 = 0; x2 = 0; cs = 0; sn = 0;
      end
      x0 = (i > 0) ? 17'(q[i-1].x0) : 17'(0);
      tick();
      if (i > 0) begin
        check($sformatf("%s[%0d]", nm, i - 1), q[i-1].e0, q[i-1].e1);
        if (rng) range_check($sformatf("%s[%0d]", nm, i - 1));
      end
    end
  endtask

  initial begin
    int c, s;
    int ang[8][2] = '{'{1024, 0}, '{724, 724}, '{0, 1024}, '{-724, 724},
                      '{-1024, 0}, '{-724, -724}, '{0, -1024}, '{724, -724}};
`ifdef FHT_BUT_ROUND_EN
    tbl.push_back(hv(32767, 32767, 32767, 1024, 0, 24575, 8192));
    tbl.push_back(hv(0, -32768, 32767, 0, 1024, 8192, -8192));
    tbl.push_back(hv(32767, 0, -32768, 0, -1024, 24576, 8192));
    tbl.push_back(hv(-1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(hv(0, 32767, -32768, -724, 724, -11584, 11584));
`else
    tbl.push_back(hv(32767, 32767, 32767, 1024, 0, 24575, 8191));
    tbl.push_back(hv(0, -32768, 32767, 0, 1024, 8191, -8192));
    tbl.push_back(hv(32767, 0, -32768, 0, -1024, 24575, 8191));
    tbl.push_back(hv(-1, 0, 0, 0, 0, -1, -1));
    tbl.push_back(hv(0, 32767, -32768, -724, 724, -11584, 11583));
`endif
    tbl.push_back(hv(-32768, -32768, -32768, 724, 724, -27968, -4800));
    tbl.push_back(hv(50, 100, 7, -1024, 0, 0, 50));
    tbl.push_back(hv(0, 0, 0, 0, 0, 0, 0));

    rst = 1; x0 = 1000; x1 = 2000; x2 = -3000; cs = 724; sn = 724;
    tick(); tick();
    check("reset_hold", 0, 0);
    rst = 0; x0 = 17'(tbl[0].x0); x1 = 17'(tbl[0].x1); x2 = 17'(tbl[0].x2);
    cs = 12'(tbl[0].c); sn = 12'(tbl[0].s);
    tick(); tick();
    check("first_after_reset", tbl[0].e0, tbl[0].e1);

    cs = 1024; sn = 0; x1 = 32767; x2 = 0; x0 = 0;
    tick();
    rst = 1;
    tick();
    check("midstream_reset", 0, 0);
    rst = 0; cs = 0; sn = 0; x1 = 0; x2 = 0; x0 = 0;
    tick();
    check("p_cleared", 0, 0);

    q = tbl;
    run_stream("table", 0);

    q.delete();
    foreach (ang[a])
      for (int d = 0; d < 8; d++)
        q.push_back(mk(d[0] ? 32767 : -32768, d[1] ? 32767 : -32768,
                       d[2] ? 32767 : -32768, ang[a][0], ang[a][1]));
    run_stream("sweep", 1);

    q.delete();
    for (int i = 0; i < 1000; i++) begin
      do begin
        c = $urandom_range(2048) - 1024;
        s = $urandom_range(2048) - 1024;
      end while (c * c + s * s > 1024 * 1024);
      q.push_back(mk($urandom_range(65535) - 32768, $urandom_range(65535) - 32768,
                     $urandom_range(65535) - 32768, c, s));
    end
    run_stream("rand", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fht_but_r2.md
Name: fht_but_r2

Overview:
- Two-point radix-2 butterfly for the fast Hartley transform (FHT) datapath.
- Rotates a pair of samples (x1, x2) by a twiddle (cos, sin) and adds/subtracts the result to/from a third sample x0.
- Both outputs are scaled by 1/2 per stage to prevent growth across stages.
- Two-stage pipeline; sits between the FHT sample RAM read ports and write-back, with the address/twiddle sequencer feeding it.

Parameters:
- D_SIZE, 17, width of signed data inputs and outputs.
- W_SIZE, 12, width of signed twiddle coefficients.
- W_SHIFT, 10, log2 of coefficient unity (1.0 == 1024).

Ports:
- iCLK  in  1  clock; all registers update on the rising edge.
- iRESET  in  1  reset; synchronous, active-high.
- iX_0  in  D_SIZE  signed sample x0; sampled one cycle after x1/x2/coefs.
- iX_1  in  D_SIZE  signed sample x1 (cos branch).
- iX_2  in  D_SIZE  signed sample x2 (sin branch).
- iSIN  in  W_SIZE  signed sin twiddle, scaled by 2^W_SHIFT.
- iCOS  in  W_SIZE  signed cos twiddle, scaled by 2^W_SHIFT.
- oY_0  out  D_SIZE  signed sum output, registered.
- oY_1  out  D_SIZE  signed difference output, registered.

Behaviour:
- Stage 1, edge k:
  - P <= iCOS*iX_1 + iSIN*iX_2, signed.
  - Each product is D_SIZE+W_SIZE bits; P is D_SIZE+W_SIZE+1 bits (30 bits by default); no truncation.
- Stage 2, edge k+1:
  - A = iX_0 sign-extended and shifted left by W_SHIFT+1 (x0 * 2^11).
  - S0 = A + P, S1 = A - P, both signed, 1 bit wider than P.
  - oY_0 <= S0 >>> (W_SHIFT+2); oY_1 <= S1 >>> (W_SHIFT+2).
  - Rounding mode is set by the optional feature.
- Mathematical result:
  - y0 = (x0 + P/2^(W_SHIFT+1))/2.
  - y1 = (x0 - P/2^(W_SHIFT+1))/2.
  - |oY - exact| < 1 LSB in every case.
- Latency and timing:
  - Outputs reflect x1/x2/sin/cos presented before edge k and x0 presented before edge k+1.
  - Outputs are readable after edge k+1.
  - Throughput: one butterfly per clock, fully pipelined; no handshake, no stall.
- Width and range:
  - Legal inputs: data in [-32768, 32767], sin^2+cos^2 <= 1024^2.
  - Under these limits |y| <= 27969, so the result fits D_SIZE.
  - Result is taken as the low D_SIZE bits of the shifted sum; no saturation.
- Reset:
  - While iRESET=1 at a rising edge, P, oY_0 and oY_1 clear to 0.
  - The first valid output appears two edges after iRESET deasserts.
  - Reset mid-stream discards in-flight data.
- Coefficient extremes (cos=+/-1024 or sin=+/-1024) need 12-bit signed coefs; -1024 and 1024 are both in range (+/-2047).

Optional Feature:
- Macro FHT_BUT_ROUND_EN.
- Defined: round to nearest, half toward +inf. Add 2^(W_SHIFT+1) to S0/S1 before the arithmetic right shift of W_SHIFT+2; |error| <= 0.5 LSB.
- Undefined: plain arithmetic shift (floor); 0 <= exact-oY < 1 LSB.
- No other behaviour differs.

Test Plan:
- Reset: hold iRESET=1 two cycles with nonzero inputs -> oY_0=oY_1=0; after release the first valid result appears at the second edge.
- Identity twiddle: x1=x2=32767, cos=1024, sin=0, then x0=32767 next cycle.
  - Exact values: y0=24575.25, y1=8191.75.
  - Floor: 24575/8191. ROUND_EN: 24575/8192.
- 45 degrees: cos=sin=724, x1=x2=-32768, then x0=-32768 -> oY_0=-27968, oY_1=-4800 in both modes.
- 90 degrees: cos=0, sin=1024, x1=-32768, x2=32767, then x0=0.
  - Exact values: y0=8191.75, y1=-8191.75.
  - Floor: 8191/-8192. ROUND_EN: 8192/-8192.
- Spec-angle sweep:
  - Twiddles: all 8 multiples of 45 degrees (0, +/-724, +/-1024 pairs).
  - Data: every combination of x0,x1,x2 in {-32768, 32767}.
  - Required: |oY - ref| < 1 and |oY| <= 32767 for all 64 cases.
- Random back-to-back: new inputs every cycle, 1000 vectors with random data and coefs constrained to sin^2+cos^2 <= 1024^2 -> each output matches the reference model two edges later, error < 1 LSB, no overflow.
